// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid
// buffer, flush/freeze control, side-bit squashing, sticky halt and stall counter.
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int SIDE_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIDE_W-1:0] in_side,
    input  logic              in_halt,
    input  logic              flush,
    input  logic              en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SIDE_W-1:0] out_side,
    output logic              out_halt,
    output logic              halt_latched,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] data;
        logic [SIDE_W-1:0] side;
        logic              halt;
    } entry_t;

    entry_t             head_q, head_d;
    entry_t             skid_q, skid_d;
    entry_t             in_entry;
    logic               in_ready_q, in_ready_d;
    logic               halt_q, halt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_xfer, out_xfer;

    assign out_valid    = head_q.vld & en;
    assign out_data     = head_q.data;
    assign out_side     = head_q.side & {SIDE_W{out_valid}};
    assign out_halt     = head_q.halt & out_valid;
    assign in_ready     = in_ready_q;
    assign halt_latched = halt_q;
    assign stall_cnt    = cnt_q;
    assign occupancy    = {1'b0, head_q.vld} + {1'b0, skid_q.vld};

    assign in_xfer  = in_valid & in_ready_q & en;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        in_entry.vld  = 1'b1;
        in_entry.data = in_data;
        in_entry.side = in_side;
        in_entry.halt = in_halt;

        head_d = head_q;
        skid_d = skid_q;
        halt_d = halt_q | (out_xfer & head_q.halt);
        cnt_d  = cnt_q;

        if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);

        // in_ready is low whenever the skid is occupied, so an accept and a
        // full skid never coincide; the skid only ever refills the head.
        if (flush) begin
            head_d = '0;
            skid_d = '0;
        end else if (out_xfer) begin
            head_d = skid_q.vld ? skid_q : (in_xfer ? in_entry : '0);
            skid_d = '0;
        end else if (in_xfer) begin
            if (head_q.vld)
                skid_d = in_entry;
            else
                head_d = in_entry;
        end

        in_ready_d = !skid_d.vld && !halt_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            halt_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            halt_q     <= halt_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
